// File: rtl/ld_sequencer_pkg.sv
// Shared definitions for the laser-diode sequencer: state codes, default thresholds, and the state-to-driver-level map.
// Latency: not applicable; this package holds only types, constants and a pure function.
// Backpressure: not applicable.
package ld_sequencer_pkg;

    // State codes are visible on state_o and are also decoded by the driver
    // side, so these encodings must stay fixed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_RAMP_UP  = 3'd2,
        ST_LASE     = 3'd3,
        ST_RAMP_DN  = 3'd4,
        ST_SHUTDOWN = 3'd5,
        ST_FAULT    = 3'd6
    } ld_state_t;

    localparam int unsigned DEB_CYCLES_DEF   = 1000;
    localparam logic [11:0] I_MAX_DEF        = 12'd2000;
    localparam logic [11:0] I_MIN_DEF        = 12'd1;
    localparam int unsigned RAMP_TIMEOUT_DEF = 1200000;
    localparam int unsigned TMR_W_DEF        = 21;
    localparam logic [11:0] DROOP_TOL_DEF    = 12'd16;

    // Driver enable levels for a state, returned as {SW_ON, LD_ON}.
    function automatic logic [1:0] drv_levels(input ld_state_t s);
        logic [1:0] lv;
        lv = 2'b00;
        case (s)
            ST_ARMED:   lv = 2'b10;
            ST_RAMP_UP: lv = 2'b11;
            ST_LASE:    lv = 2'b11;
            ST_RAMP_DN: lv = 2'b10;
            default:    lv = 2'b00;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/ld_sequencer_if.sv
// Panel/driver signal bundle for ld_sequencer.
// Latency: wires only; this interface adds no delay.
// Backpressure: none; all signals are levels.
//   btn_sw, btn_ld : raw front-panel buttons (async, active-high)
//   I_fb           : 12-bit driver current readback
//   SW_ON, LD_ON   : driver enables; state_o: FSM state code; ready/fault: status
// The slave modport is the sequencer's view. The master modport is the view of the panel and driver side.
interface ld_sequencer_if;
    logic        btn_sw;
    logic        btn_ld;
    logic [11:0] I_fb;
    logic        SW_ON;
    logic        LD_ON;
    logic [2:0]  state_o;
    logic        ready;
    logic        fault;

    modport master (
        output btn_sw, btn_ld, I_fb,
        input  SW_ON, LD_ON, state_o, ready, fault
    );

    modport slave (
        input  btn_sw, btn_ld, I_fb,
        output SW_ON, LD_ON, state_o, ready, fault
    );
endinterface

// File: rtl/ld_sequencer_debounce.sv
// Button debouncer: 2-FF synchroniser, a stability counter, and a press pulse on the rising edge of the accepted level.
// Latency: the pulse appears 2 + DEB_CYCLES cycles after the button edge.
// Backpressure: none. The pulse lasts one cycle and is not held.
//   CLK, Clrn : clock and async active-low reset
//   i_btn     : raw button level
//   o_pulse   : one-cycle pulse each time a new high level is accepted
module ld_sequencer_debounce #(
    parameter int unsigned DEB_CYCLES = 1000
) (
    input  logic CLK,
    input  logic Clrn,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    // The counter runs only while the synchronised sample disagrees with the
    // accepted level. Any sample that agrees restarts it, so bounces shorter
    // than DEB_CYCLES never reach the accept point.
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_pulse <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/ld_sequencer.sv
// Laser-diode command sequencer. It debounces the panel buttons, drives SW_ON/LD_ON, follows I_fb through each ramp, and latches a fault when a ramp stalls.
// Latency: the FSM acts one cycle after a debounced press pulse, and the outputs are registered from the next state.
// Backpressure: none. A press that arrives in a state that ignores it is dropped.
//   CLK, Clrn : clock and async active-low reset
//   bus       : ld_sequencer_if.slave with the buttons, I_fb, SW_ON/LD_ON, state_o, ready, fault
// Optional build macro LD_DROOP_CHECK_EN: while in LASE, a current sag below I_MAX-DROOP_TOL raises a fault.
module ld_sequencer
    import ld_sequencer_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter logic [11:0] I_MAX        = I_MAX_DEF,
    parameter logic [11:0] I_MIN        = I_MIN_DEF,
    parameter int unsigned RAMP_TIMEOUT = RAMP_TIMEOUT_DEF,
    parameter int unsigned TMR_W        = TMR_W_DEF
`ifdef LD_DROOP_CHECK_EN
    ,
    parameter logic [11:0] DROOP_TOL    = DROOP_TOL_DEF
`endif
) (
    input  logic        CLK,
    input  logic        Clrn,
    ld_sequencer_if.slave bus
);

    localparam logic [TMR_W-1:0] TMR_TO = RAMP_TIMEOUT[TMR_W-1:0];

    ld_state_t        r_state;
    ld_state_t        w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic             r_sw_on;
    logic             r_ld_on;
    logic             r_ready;
    logic             r_fault;

    logic w_sw_p;
    logic w_ld_p;
    logic w_full;
    logic w_off;
    logic w_timeout;
    logic w_timed;
`ifdef LD_DROOP_CHECK_EN
    logic w_droop;
`endif

    ld_sequencer_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
        .CLK     (CLK),
        .Clrn    (Clrn),
        .i_btn   (bus.btn_sw),
        .o_pulse (w_sw_p)
    );

    ld_sequencer_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ld (
        .CLK     (CLK),
        .Clrn    (Clrn),
        .i_btn   (bus.btn_ld),
        .o_pulse (w_ld_p)
    );

    // A readback above I_MAX counts as full current. The driver can overshoot slightly at the top of a ramp.
    assign w_full    = (bus.I_fb >= I_MAX);
    assign w_off     = (bus.I_fb <= I_MIN);
    assign w_timeout = (r_tmr == TMR_TO);
    assign w_timed   = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DN) ||
                       (r_state == ST_SHUTDOWN);
`ifdef LD_DROOP_CHECK_EN
    assign w_droop   = (bus.I_fb < (I_MAX - DROOP_TOL));
`endif

    // Inside each state the tests are ordered by priority: power press, then laser press, then current threshold, then timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sw_p) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_sw_p)      w_state_nxt = ST_IDLE;
                else if (w_ld_p) w_state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (w_sw_p)         w_state_nxt = ST_SHUTDOWN;
                else if (w_ld_p)    w_state_nxt = ST_RAMP_DN;
                else if (w_full)    w_state_nxt = ST_LASE;
                else if (w_timeout) w_state_nxt = ST_FAULT;
            end
            ST_LASE: begin
                if (w_sw_p)       w_state_nxt = ST_SHUTDOWN;
                else if (w_ld_p)  w_state_nxt = ST_RAMP_DN;
`ifdef LD_DROOP_CHECK_EN
                else if (w_droop) w_state_nxt = ST_FAULT;
`endif
            end
            ST_RAMP_DN: begin
                if (w_sw_p)         w_state_nxt = ST_SHUTDOWN;
                else if (w_ld_p)    w_state_nxt = ST_RAMP_UP;
                else if (w_off)     w_state_nxt = ST_ARMED;
                else if (w_timeout) w_state_nxt = ST_FAULT;
            end
            ST_SHUTDOWN: begin
                // The driver is already powering down, so button presses are ignored until the current has fully decayed.
                if (w_off)          w_state_nxt = ST_IDLE;
                else if (w_timeout) w_state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                // Clearing the fault takes a deliberate power press, and only while no current flows.
                if (w_sw_p && w_off) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The timer measures time spent in the current state. It restarts on every state change and holds once it reaches the timeout value.
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            r_tmr <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmr <= '0;
        end else if (w_timed && !w_timeout) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // Outputs are registered from the next state. This keeps them glitch-free and in step with state_o.
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            r_sw_on <= 1'b0;
            r_ld_on <= 1'b0;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            {r_sw_on, r_ld_on} <= drv_levels(w_state_nxt);
            r_ready <= (w_state_nxt == ST_LASE);
            r_fault <= (w_state_nxt == ST_FAULT);
        end
    end

    assign bus.SW_ON   = r_sw_on;
    assign bus.LD_ON   = r_ld_on;
    assign bus.state_o = r_state;
    assign bus.ready   = r_ready;
    assign bus.fault   = r_fault;

endmodule

// File: tb/tb_ld_sequencer.sv
// Testbench for ld_sequencer with DEB_CYCLES=4 and RAMP_TIMEOUT=50. A cycle-level reference model predicts every output.
// Latency: not applicable. The model is stepped on each rising edge and the DUT outputs are compared on the falling edge.
// Backpressure: not applicable.
module tb_ld_sequencer;

    localparam int DEB   = 4;
    localparam int TO    = 50;
    localparam int IMAX  = 2000;
    localparam int IMIN  = 1;
    localparam int DROOP = 16;

    logic CLK;
    logic Clrn;

    ld_sequencer_if u_if ();

    ld_sequencer #(
        .DEB_CYCLES   (DEB),
        .RAMP_TIMEOUT (TO)
    ) u_dut (
        .CLK  (CLK),
        .Clrn (Clrn),
        .bus  (u_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model. State codes: 0 IDLE, 1 ARMED, 2 RAMP_UP, 3 LASE, 4 RAMP_DN, 5 SHUTDOWN, 6 FAULT.
    int m_state;
    int m_dwell;        // cycles spent so far in the current timed state
    bit m_sw_lvl, m_ld_lvl;
    bit m_swp, m_ldp;   // press pulses that the FSM will consume on the next edge
    bit h_sw[8];        // raw button samples; index 0 is the most recent edge
    bit h_ld[8];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0;
        m_dwell = 0;
        m_sw_lvl = 0; m_ld_lvl = 0;
        m_swp = 0; m_ldp = 0;
        for (int k = 0; k < 8; k++) begin
            h_sw[k] = 0;
            h_ld[k] = 0;
        end
    endtask

    function automatic int model_next(input int s, input bit sw, input bit ld,
                                      input int i, input bit to);
        int ns;
        ns = s;
        case (s)
            0: if (sw) ns = 1;
            1: if (sw) ns = 0; else if (ld) ns = 2;
            2: if (sw) ns = 5; else if (ld) ns = 4; else if (i >= IMAX) ns = 3;
               else if (to) ns = 6;
            3: begin
                if (sw) ns = 5; else if (ld) ns = 4;
`ifdef LD_DROOP_CHECK_EN
                else if (i < IMAX - DROOP) ns = 6;
`endif
            end
            4: if (sw) ns = 5; else if (ld) ns = 2; else if (i <= IMIN) ns = 1;
               else if (to) ns = 6;
            5: if (i <= IMIN) ns = 0; else if (to) ns = 6;
            6: if (sw && i <= IMIN) ns = 0;
            default: ns = 0;
        endcase
        return ns;
    endfunction

    // A level is accepted when the synchronised samples, which lag the raw button by two edges, have shown the opposite value for DEB samples in a row.
    function automatic bit window_is(input bit h[8], input bit v);
        bit ok;
        ok = 1;
        for (int k = 2; k < DEB + 2; k++) if (h[k] != v) ok = 0;
        return ok;
    endfunction

    task automatic model_edge();
        int ns;
        bit to;
        to = (m_dwell == TO);
        ns = model_next(m_state, m_swp, m_ldp, int'(u_if.I_fb), to);
        if (ns != m_state) m_dwell = 0;
        else if ((m_state == 2 || m_state == 4 || m_state == 5) && m_dwell < TO) m_dwell++;
        m_state = ns;
        for (int k = 7; k > 0; k--) begin
            h_sw[k] = h_sw[k-1];
            h_ld[k] = h_ld[k-1];
        end
        h_sw[0] = u_if.btn_sw;
        h_ld[0] = u_if.btn_ld;
        if (window_is(h_sw, !m_sw_lvl)) begin m_sw_lvl = !m_sw_lvl; m_swp = m_sw_lvl; end
        else m_swp = 0;
        if (window_is(h_ld, !m_ld_lvl)) begin m_ld_lvl = !m_ld_lvl; m_ldp = m_ld_lvl; end
        else m_ldp = 0;
    endtask

    task automatic check_all();
        int es, el;
        es = (m_state >= 1 && m_state <= 4) ? 1 : 0;
        el = (m_state == 2 || m_state == 3) ? 1 : 0;
        check("state_o", int'(u_if.state_o), m_state);
        check("SW_ON", int'(u_if.SW_ON), es);
        check("LD_ON", int'(u_if.LD_ON), el);
        check("ready", int'(u_if.ready), (m_state == 3) ? 1 : 0);
        check("fault", int'(u_if.fault), (m_state == 6) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Hold the selected buttons for 8 cycles, which is long enough for the press to be accepted and acted on, then release them.
    task automatic press(input bit sw, input bit ld);
        u_if.btn_sw = sw;
        u_if.btn_ld = ld;
        run(8);
        u_if.btn_sw = 1'b0;
        u_if.btn_ld = 1'b0;
    endtask

    task automatic async_reset();
        #2 Clrn = 1'b0;
        #1;
        check("arst_SW_ON", int'(u_if.SW_ON), 0);
        check("arst_LD_ON", int'(u_if.LD_ON), 0);
        check("arst_state", int'(u_if.state_o), 0);
        u_if.btn_sw = 1'b0;
        u_if.btn_ld = 1'b0;
        @(negedge CLK);
        Clrn = 1'b1;
        m_reset();
    endtask

    int ivals[8];

    initial begin
        int first_on;
        int w;
        ivals = '{0, 1, 2, 500, 1999, 2000, 4095, 1980};
        m_reset();
        Clrn = 1'b0;
        u_if.btn_sw = 1'b0;
        u_if.btn_ld = 1'b0;
        u_if.I_fb = 12'd0;
        #2;
        check("rst_state", int'(u_if.state_o), 0);
        check("rst_SW_ON", int'(u_if.SW_ON), 0);
        check("rst_LD_ON", int'(u_if.LD_ON), 0);
        check("rst_ready", int'(u_if.ready), 0);
        check("rst_fault", int'(u_if.fault), 0);
        @(negedge CLK);
        @(negedge CLK);
        Clrn = 1'b1;
        run(3);

        // Scenario 1: power on, start the laser ramp, reach full current.
        u_if.btn_sw = 1'b1;
        first_on = 99;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (u_if.SW_ON === 1'b1 && first_on == 99) first_on = c;
        end
        u_if.btn_sw = 1'b0;
        check("sw_on_latency_le8", (first_on <= 8) ? 1 : 0, 1);
        check("s1_armed", int'(u_if.state_o), 1);
        run(7);
        press(0, 1);
        check("s1_ramp_up", int'(u_if.state_o), 2);
        check("s1_ld_on", int'(u_if.LD_ON), 1);
        u_if.I_fb = 12'($urandom_range(2, 1999));
        run(4);
        check("s1_still_ramp", int'(u_if.state_o), 2);
        u_if.I_fb = 12'(2000 + $urandom_range(0, 2095));
        tick();
        check("s1_ready", int'(u_if.ready), 1);
        run(7);

        // Scenario 2: laser off from LASE, then ramp down to ARMED.
        press(0, 1);
        check("s2_ramp_dn", int'(u_if.state_o), 4);
        check("s2_ld_off", int'(u_if.LD_ON), 0);
        u_if.I_fb = 12'($urandom_range(2, 1999));
        run(3);
        check("s2_still_dn", int'(u_if.state_o), 4);
        u_if.I_fb = 12'($urandom_range(0, 1));
        tick();
        check("s2_armed", int'(u_if.state_o), 1);
        run(7);

        // Scenario 3: the ramp stalls at 500 and times out into FAULT.
        u_if.I_fb = 12'd500;
        press(0, 1);
        w = 0;
        while (u_if.fault !== 1'b1 && w < 80) begin
            tick();
            w++;
        end
        check("s3_fault", int'(u_if.fault), 1);
        check("s3_timeout_cycles", w, 50);
        check("s3_sw_off", int'(u_if.SW_ON), 0);
        check("s3_ld_off", int'(u_if.LD_ON), 0);
        run(7);
        press(1, 0);
        run(7);
        check("s3_fault_held_with_current", int'(u_if.state_o), 6);
        u_if.I_fb = 12'd0;
        press(1, 0);
        check("s3_cleared_idle", int'(u_if.state_o), 0);
        run(7);

        // Scenario 4: a bouncing power button produces no press.
        for (int c = 0; c < 20; c++) begin
            u_if.btn_sw = ((c / 2) % 2 == 0);
            tick();
        end
        u_if.btn_sw = 1'b0;
        run(8);
        check("s4_bounce_idle", int'(u_if.state_o), 0);

        // Scenario 5: power and laser pressed together in ARMED; power wins.
        press(1, 0);
        check("s5_armed", int'(u_if.state_o), 1);
        run(7);
        press(1, 1);
        check("s5_idle", int'(u_if.state_o), 0);
        check("s5_ld_off", int'(u_if.LD_ON), 0);
        run(7);

        // Scenario 7: asynchronous reset in the middle of a ramp.
        press(1, 0);
        run(7);
        u_if.I_fb = 12'd300;
        press(0, 1);
        check("s7_ramp_up", int'(u_if.state_o), 2);
        async_reset();
        run(3);

        // Scenario 6: the current droops slightly while in LASE.
        u_if.I_fb = 12'd0;
        press(1, 0);
        run(7);
        press(0, 1);
        u_if.I_fb = 12'd2000;
        tick();
        check("s6_ready", int'(u_if.ready), 1);
        run(7);
        u_if.I_fb = 12'd1980;
        tick();
`ifdef LD_DROOP_CHECK_EN
        check("s6_droop_fault", int'(u_if.state_o), 6);
`else
        check("s6_no_droop_check", int'(u_if.state_o), 3);
`endif
        run(3);

        // Randomised phase: random presses and current levels, all checked against the model.
        repeat (150) begin
            case ($urandom_range(0, 3))
                0: u_if.btn_sw = 1'b1;
                1: u_if.btn_ld = 1'b1;
                2: begin u_if.btn_sw = 1'b1; u_if.btn_ld = 1'b1; end
                default: ;
            endcase
            u_if.I_fb = 12'(ivals[$urandom_range(0, 7)]);
            run($urandom_range(1, 12));
            u_if.btn_sw = 1'b0;
            u_if.btn_ld = 1'b0;
            run($urandom_range(0, 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
